// File: rtl/ssio_ddr_in_cal_pkg.sv
// ssio_ddr_in_cal_pkg: shared FSM encoding and counter width for the DDR input eye-centring controller
package ssio_ddr_in_cal_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_DONE
  } state_t;
  localparam int CNT_W = 16;
endpackage

// File: rtl/ssio_ddr_in_cal_lane.sv
// ssio_ddr_in_cal_lane: per-lane pass accumulator and longest-window tracker
// Ports: clk, rst_n (async active-low); clear restarts statistics; sample_valid/pass accumulate
// the per-tap verdict; eval closes the tap; last_tap forces an open run closed; tap is the current tap.
// centre/fail reflect the best window including the update being made this cycle.
module ssio_ddr_in_cal_lane #(
  parameter int TAP_WIDTH  = 9,
  parameter int MIN_WINDOW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic                 pass,
  input  logic                 eval,
  input  logic                 last_tap,
  input  logic [TAP_WIDTH-1:0] tap,
  output logic [TAP_WIDTH-1:0] centre,
  output logic                 fail
);
  localparam int LW = TAP_WIDTH + 1;
  logic          ok, close, take;
  logic [LW-1:0] cur_start, cur_len, best_start, best_len;
  logic [LW-1:0] ext_start, ext_len, nb_start, nb_len;
  always_comb begin
    ext_len   = ok ? cur_len + 1'b1 : cur_len;
    ext_start = (ok && cur_len == '0) ? LW'(tap) : cur_start;
    close     = !ok || last_tap;
    take      = eval && close && ext_len > best_len;
    nb_len    = take ? ext_len : best_len;
    nb_start  = take ? ext_start : best_start;
  end
  assign centre = TAP_WIDTH'(nb_start + (nb_len >> 1));
  assign fail   = nb_len < LW'(MIN_WINDOW);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      ok         <= 1'b1;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else begin
      ok         <= eval ? 1'b1 : (sample_valid ? ok & pass : ok);
      cur_start  <= eval ? ext_start : cur_start;
      cur_len    <= eval ? (close ? '0 : ext_len) : cur_len;
      best_start <= nb_start;
      best_len   <= nb_len;
    end
  end
endmodule

// File: rtl/ssio_ddr_in_cal.sv
// ssio_ddr_in_cal: sweeps all IDELAY lanes over 0..MAX_TAP and loads each lane's passing-window centre
// Ports: clk, rst_n (async active-low); cal_start pulse; rdy_idelay from the delay controller;
// q1/q2 per-lane DDR samples; delay_en_vtc, delay_load, delay_cnt_value drive the delay lines;
// cal_busy, cal_done, cal_fail report progress and per-lane result. All outputs registered.
module ssio_ddr_in_cal
  import ssio_ddr_in_cal_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               TAP_WIDTH     = 9,
  parameter int               MAX_TAP       = 511,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               SAMPLE_CYCLES = 64,
  parameter int               MIN_WINDOW    = 4,
  parameter int               DEFAULT_TAP   = 0,
  parameter logic [WIDTH-1:0] PATTERN_Q1    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PATTERN_Q2    = {WIDTH{1'b0}},
  parameter bit               AUTO_START    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cal_start,
  input  logic                       rdy_idelay,
  input  logic [WIDTH-1:0]           q1,
  input  logic [WIDTH-1:0]           q2,
  output logic                       delay_en_vtc,
  output logic [WIDTH-1:0]           delay_load,
  output logic [WIDTH*TAP_WIDTH-1:0] delay_cnt_value,
  output logic                       cal_busy,
  output logic                       cal_done,
  output logic [WIDTH-1:0]           cal_fail
);
  state_t                     state, nxt;
  logic [TAP_WIDTH-1:0]       tap, tap_nxt;
  logic [CNT_W-1:0]           cnt;
  logic                       auto_q, going_wait, last_tap, sweeping;
  logic [WIDTH-1:0]           pass, lane_fail;
  logic [WIDTH*TAP_WIDTH-1:0] apply_val;
  assign last_tap = tap == TAP_WIDTH'(MAX_TAP);
  assign pass     = ~((q1 ^ PATTERN_Q1) | (q2 ^ PATTERN_Q2));
  assign sweeping = state == S_LOAD || state == S_SETTLE || state == S_SAMPLE ||
                    state == S_EVAL || state == S_APPLY;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = (cal_start || auto_q) ? S_WAIT_RDY : S_IDLE;
      S_WAIT_RDY: nxt = rdy_idelay ? S_LOAD : S_WAIT_RDY;
      S_LOAD:     nxt = S_SETTLE;
      S_SETTLE:   nxt = cnt == CNT_W'(SETTLE_CYCLES - 1) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE:   nxt = cnt == CNT_W'(SAMPLE_CYCLES - 1) ? S_EVAL : S_SAMPLE;
      S_EVAL:     nxt = last_tap ? S_APPLY : S_LOAD;
      S_APPLY:    nxt = S_DONE;
      S_DONE:     nxt = cal_start ? S_WAIT_RDY : S_DONE;
      default:    nxt = S_IDLE;
    endcase
    nxt        = (sweeping && !rdy_idelay) ? S_WAIT_RDY : nxt;
    going_wait = nxt == S_WAIT_RDY && state != S_WAIT_RDY;
    tap_nxt    = going_wait ? '0 : (state == S_EVAL && nxt == S_LOAD) ? tap + 1'b1 : tap;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [TAP_WIDTH-1:0] c;
    ssio_ddr_in_cal_lane #(.TAP_WIDTH(TAP_WIDTH), .MIN_WINDOW(MIN_WINDOW)) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (going_wait),
      .sample_valid (state == S_SAMPLE),
      .pass         (pass[i]),
      .eval         (state == S_EVAL),
      .last_tap     (last_tap),
      .tap          (tap),
      .centre       (c),
      .fail         (lane_fail[i])
    );
    assign apply_val[i*TAP_WIDTH +: TAP_WIDTH] = lane_fail[i] ? TAP_WIDTH'(DEFAULT_TAP) : c;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tap    <= '0;
      cnt    <= '0;
      auto_q <= AUTO_START;
    end else begin
      state  <= nxt;
      tap    <= tap_nxt;
      cnt    <= nxt != state ? '0 : cnt + 1'b1;
      auto_q <= state == S_IDLE ? 1'b0 : auto_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_en_vtc    <= 1'b1;
      delay_load      <= '0;
      delay_cnt_value <= '0;
      cal_busy        <= 1'b0;
      cal_done        <= 1'b0;
      cal_fail        <= '0;
    end else begin
      delay_load      <= (nxt == S_LOAD || nxt == S_APPLY) ? '1 : '0;
      delay_cnt_value <= nxt == S_LOAD ? {WIDTH{tap_nxt}} : nxt == S_APPLY ? apply_val : delay_cnt_value;
      cal_fail        <= going_wait ? '0 : nxt == S_APPLY ? lane_fail : cal_fail;
      cal_done        <= going_wait ? 1'b0 : state == S_DONE ? 1'b1 : cal_done;
      cal_busy        <= going_wait ? 1'b1 : state == S_DONE ? 1'b0 : cal_busy;
      delay_en_vtc    <= going_wait ? 1'b0 : state == S_DONE ? 1'b1 : delay_en_vtc;
    end
  end
endmodule

// File: tb/tb_ssio_ddr_in_cal.sv
// tb_ssio_ddr_in_cal: scoreboard bench with a delay-line model driving the pattern inside per-lane pass windows
module tb_ssio_ddr_in_cal;
  logic        clk = 1'b0;
  logic        rst_n, cal_start, rdy_idelay;
  logic [1:0]  q1, q2, delay_load, cal_fail;
  logic [17:0] delay_cnt_value;
  logic        delay_en_vtc, cal_busy, cal_done;
  logic [31:0] m [2];
  logic [8:0]  lt [2];
  int          tests = 0, fails = 0, cyc = 0, start_cyc = 0, loads = 0;
  logic        done_prev = 1'b0;
  typedef struct {
    string      nm;
    logic [8:0] c0, c1;
    logic [1:0] f;
    int         lat, nload;
  } exp_t;
  exp_t sb[$];

  ssio_ddr_in_cal #(
    .WIDTH(2), .TAP_WIDTH(9), .MAX_TAP(31), .SETTLE_CYCLES(4), .SAMPLE_CYCLES(8),
    .MIN_WINDOW(4), .DEFAULT_TAP(7), .AUTO_START(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .rdy_idelay(rdy_idelay),
    .q1(q1), .q2(q2), .delay_en_vtc(delay_en_vtc), .delay_load(delay_load),
    .delay_cnt_value(delay_cnt_value), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_fail(cal_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    lt[0] = '0;
    lt[1] = '0;
  end
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (delay_load[i]) lt[i] <= delay_cnt_value[i*9 +: 9];
  always_comb
    for (int i = 0; i < 2; i++) begin
      q1[i] = m[i][lt[i][4:0]];
      q2[i] = ~m[i][lt[i][4:0]];
    end

  function automatic logic [31:0] rng(int lo, int hi);
    logic [31:0] r = '0;
    for (int k = lo; k <= hi; k++) r[k] = 1'b1;
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expired(string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got no event expected one", nm);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (delay_load != 0) loads++;
      if (cal_done && !done_prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected_done: got cal_done expected none");
        end else begin
          e = sb.pop_front();
          check({e.nm, ".lane0_tap"}, delay_cnt_value[8:0], e.c0);
          check({e.nm, ".lane1_tap"}, delay_cnt_value[17:9], e.c1);
          check({e.nm, ".cal_fail"}, cal_fail, e.f);
          check({e.nm, ".busy_vtc"}, {cal_busy, delay_en_vtc}, 2'b01);
          if (e.lat >= 0) check({e.nm, ".latency"}, cyc - start_cyc - 1, e.lat);
          if (e.nload >= 0) check({e.nm, ".loads"}, loads, e.nload);
        end
      end
      done_prev = cal_done;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    start_cyc = cyc;
    loads = 0;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    for (int k = 0; k < 3000 && !cal_done; k++) @(negedge clk);
    if (!cal_done) expired(nm);
    @(negedge clk);
  endtask

  task automatic push(string nm, logic [8:0] c0, logic [8:0] c1, logic [1:0] f, int lat, int nl);
    exp_t e;
    e.nm = nm; e.c0 = c0; e.c1 = c1; e.f = f; e.lat = lat; e.nload = nl;
    sb.push_back(e);
  endtask

  task automatic sweep(string nm, logic [31:0] m0, logic [31:0] m1,
                       logic [8:0] c0, logic [8:0] c1, logic [1:0] f);
    m[0] = m0;
    m[1] = m1;
    push(nm, c0, c1, f, 451, 33);
    pulse_start();
    wait_done(nm);
  endtask

  initial begin
    rst_n = 1'b0;
    cal_start = 1'b0;
    rdy_idelay = 1'b1;
    m[0] = '0;
    m[1] = '0;
    repeat (3) @(negedge clk);
    check("rst.vtc", delay_en_vtc, 1);
    check("rst.load", delay_load, 0);
    check("rst.cnt", delay_cnt_value, 0);
    check("rst.busy", cal_busy, 0);
    check("rst.done", cal_done, 0);
    check("rst.fail", cal_fail, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle.no_auto_start", {loads[7:0], cal_busy}, 0);

    sweep("s1", rng(10, 20), rng(3, 7), 15, 5, 2'b00);
    sweep("s2_longest", rng(2, 5) | rng(12, 19), rng(3, 7), 16, 5, 2'b00);
    sweep("s2_tie_open", rng(0, 3) | rng(20, 23), rng(25, 31), 2, 28, 2'b00);
    sweep("s3_fail", rng(10, 20), rng(9, 10), 15, 7, 2'b10);
    sweep("s3_none", '0, rng(0, 31), 7, 16, 2'b01);

    m[0] = rng(10, 20);
    m[1] = rng(3, 7);
    push("s4_abort", 15, 5, 2'b00, -1, -1);
    pulse_start();
    for (int k = 0; k < 1000 && !(delay_load[0] && delay_cnt_value[8:0] == 9'd12); k++)
      @(negedge clk);
    if (!(delay_load[0] && delay_cnt_value[8:0] == 9'd12)) expired("s4_reach_tap12");
    rdy_idelay = 1'b0;
    repeat (3) @(negedge clk);
    check("s4.busy_done", {cal_busy, cal_done}, 2'b10);
    rdy_idelay = 1'b1;
    for (int k = 0; k < 50 && delay_load == 0; k++) @(negedge clk);
    if (delay_load == 0) expired("s4_reload");
    check("s4.restart_tap", delay_cnt_value, 0);
    wait_done("s4_abort");

    pulse_start();
    repeat (25) @(negedge clk);
    check("s5.pre_busy_cnt", {cal_busy, delay_cnt_value}, {1'b1, 9'd1, 9'd1});
    rst_n = 1'b0;
    #1;
    check("s5.vtc", delay_en_vtc, 1);
    check("s5.load", delay_load, 0);
    check("s5.cnt", delay_cnt_value, 0);
    check("s5.busy", cal_busy, 0);
    check("s5.done", cal_done, 0);
    check("s5.fail", cal_fail, 0);
    @(negedge clk);
    rst_n = 1'b1;
    loads = 0;
    repeat (40) @(negedge clk);
    check("s5.no_load_after_reset", loads, 0);
    check("s5.idle_busy", cal_busy, 0);

    push("s6_ignore", 15, 5, 2'b00, 451, 33);
    pulse_start();
    repeat (50) @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    wait_done("s6_ignore");
    m[0] = rng(0, 3) | rng(20, 23);
    m[1] = rng(25, 31);
    push("s6_restart", 2, 28, 2'b00, 451, 33);
    pulse_start();
    check("s6.done_vtc_busy", {cal_done, delay_en_vtc, cal_busy}, 3'b001);
    wait_done("s6_restart");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
